// File: rtl/mem_write_reg_bank.sv
// ---------------------------------------------------------------------------
// mem_write_reg_bank
//   Bank of NrOfWords x NrOfBits registers on the MEM stage data path.
//   It has one write port and one registered read port, and the read data
//   goes out on a bus that cs can tri-state. A sequential fill engine can
//   preset or clear the whole bank. State only changes on a step, where
//   step = ClockEnable & Tick.
//
//   Optional feature macro: MEM_RDW_BYPASS_EN
//     defined     : a read and a write to the same valid address on the same
//                   step return the new D (write-first forwarding).
//     not defined : the same case returns the old stored word (read-first).
//                   The write still lands.
//
//   Ports
//     Clock       in   1         rising-edge clock
//     Reset       in   1         synchronous active-high reset
//     ClockEnable in   1         global enable (step = ClockEnable & Tick)
//     Tick        in   1         simulation tick
//     WrEn        in   1         write request
//     WrAddr      in   AddrBits  write address
//     D           in   NrOfBits  write data
//     RdEn        in   1         read request
//     RdAddr      in   AddrBits  read address
//     cs          in   1         1 = Q high-Z, 0 = Q driven
//     Fill        in   1         start bulk fill (level, sampled on step)
//     Q           out  NrOfBits  registered read data, tri-stated by cs
//     RdValid     out  1         one-clock strobe: Q holds new read data
//     FillBusy    out  1         fill engine active (SWEEP or DONE)
//     FillDone    out  1         one-clock strobe after the last word is filled
// ---------------------------------------------------------------------------
module mem_write_reg_bank #(
  parameter int NrOfBits  = 8,
  parameter int NrOfWords = 16,
  parameter int AddrBits  = 4,
  parameter int FillOnes  = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                WrEn,
  input  logic [AddrBits-1:0] WrAddr,
  input  logic [NrOfBits-1:0] D,
  input  logic                RdEn,
  input  logic [AddrBits-1:0] RdAddr,
  input  logic                cs,
  input  logic                Fill,
  output logic [NrOfBits-1:0] Q,
  output logic                RdValid,
  output logic                FillBusy,
  output logic                FillDone
);

  localparam int IDX_W = (NrOfWords > 1) ? $clog2(NrOfWords) : 1;

  localparam logic [1:0] IDLE_C  = 2'd0;
  localparam logic [1:0] SWEEP_C = 2'd1;
  localparam logic [1:0] DONE_C  = 2'd2;

  // The word count is one bit wider than the address so that the
  // "address < NrOfWords" test still works when NrOfWords = 2**AddrBits.
  localparam logic [AddrBits:0]   WORDS_C     = (AddrBits+1)'(NrOfWords);
  localparam logic [AddrBits-1:0] LAST_C      = AddrBits'(NrOfWords - 1);
  localparam logic [NrOfBits-1:0] FILL_WORD_C = (FillOnes != 0) ? {NrOfBits{1'b1}}
                                                                : {NrOfBits{1'b0}};
  localparam logic [NrOfBits-1:0] ZERO_WORD_C = {NrOfBits{1'b0}};

  logic [NrOfBits-1:0] mem_r [0:NrOfWords-1];
  logic [NrOfBits-1:0] rd_data_r;
  logic                rd_valid_r;
  logic [1:0]          state_r;
  logic [AddrBits-1:0] ptr_r;
  logic                fill_busy_r;
  logic                fill_done_r;

  logic                step_s;
  logic                wr_ok_s;
  logic                rd_ok_s;
  logic                rd_in_range_s;
  logic                sweep_wr_s;
  logic [NrOfBits-1:0] rd_next_s;

  assign step_s        = ClockEnable & Tick;
  assign sweep_wr_s    = step_s & (state_r == SWEEP_C);
  // The fill engine owns the bank during SWEEP, so user writes are dropped then.
  assign wr_ok_s       = step_s & WrEn & ({1'b0, WrAddr} < WORDS_C) & (state_r != SWEEP_C);
  assign rd_ok_s       = step_s & RdEn;
  assign rd_in_range_s = ({1'b0, RdAddr} < WORDS_C);

  // Pick the data a read would capture this step, including same-address hazards.
  always_comb begin
    rd_next_s = ZERO_WORD_C;
    if (!rd_in_range_s) begin
      rd_next_s = ZERO_WORD_C;
    end
`ifdef MEM_RDW_BYPASS_EN
    else if (wr_ok_s && (WrAddr == RdAddr)) begin
      rd_next_s = D;
    end
`endif
    else begin
      rd_next_s = mem_r[RdAddr[IDX_W-1:0]];
    end
  end

  // Storage array: reset clear, fill sweep, and the user write port.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NrOfWords; i++) begin
        mem_r[i] <= ZERO_WORD_C;
      end
    end else if (sweep_wr_s) begin
      mem_r[ptr_r[IDX_W-1:0]] <= FILL_WORD_C;
    end else if (wr_ok_s) begin
      mem_r[WrAddr[IDX_W-1:0]] <= D;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Read port register and its one-clock valid strobe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_data_r  <= ZERO_WORD_C;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_ok_s;
      if (rd_ok_s) begin
        rd_data_r <= rd_next_s;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  // Fill engine FSM: IDLE -> SWEEP (one word per step) -> DONE (one clock) -> IDLE.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= IDLE_C;
      ptr_r       <= {AddrBits{1'b0}};
      fill_busy_r <= 1'b0;
      fill_done_r <= 1'b0;
    end else begin
      fill_done_r <= 1'b0;
      case (state_r)
        IDLE_C: begin
          if (step_s && Fill) begin
            state_r     <= SWEEP_C;
            ptr_r       <= {AddrBits{1'b0}};
            fill_busy_r <= 1'b1;
          end else begin
            fill_busy_r <= 1'b0;
          end
        end
        SWEEP_C: begin
          fill_busy_r <= 1'b1;
          if (step_s) begin
            ptr_r <= ptr_r + AddrBits'(1);
            if (ptr_r == LAST_C) begin
              state_r     <= DONE_C;
              fill_done_r <= 1'b1;
            end else begin
              state_r <= SWEEP_C;
            end
          end else begin
            state_r <= SWEEP_C;
          end
        end
        // DONE lasts exactly one clock, whether or not there is a step.
        DONE_C: begin
          state_r     <= IDLE_C;
          fill_busy_r <= 1'b0;
        end
        default: begin
          state_r     <= IDLE_C;
          ptr_r       <= {AddrBits{1'b0}};
          fill_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign Q        = cs ? {NrOfBits{1'bz}} : rd_data_r;
  assign RdValid  = rd_valid_r;
  assign FillBusy = fill_busy_r;
  assign FillDone = fill_done_r;

endmodule

// File: tb/tb_mem_write_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_mem_write_reg_bank
//   Directed test bench for mem_write_reg_bank with a read scoreboard.
//   The stimulus pushes the expected read data into a queue when it issues a
//   read. A monitor process pops one entry and compares it with Q on every
//   RdValid strobe. Fill timing, reset state and tri-state are checked
//   directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_mem_write_reg_bank;

  localparam int NB = 8;
  localparam int NW = 16;
  localparam int AB = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          ce;
  logic          tick;
  logic          wr_en;
  logic [AB-1:0] wr_addr;
  logic [NB-1:0] d;
  logic          rd_en;
  logic [AB-1:0] rd_addr;
  logic          cs;
  logic          fill;
  wire  [NB-1:0] q;
  logic          rd_valid;
  logic          fill_busy;
  logic          fill_done;

  int            checks = 0;
  int            fails  = 0;
  logic [NB-1:0] exp_q [$];
  logic [NB-1:0] model [NW];

  mem_write_reg_bank #(
    .NrOfBits (NB),
    .NrOfWords(NW),
    .AddrBits (AB),
    .FillOnes (1)
  ) dut (
    .Clock      (clock),
    .Reset      (reset),
    .ClockEnable(ce),
    .Tick       (tick),
    .WrEn       (wr_en),
    .WrAddr     (wr_addr),
    .D          (d),
    .RdEn       (rd_en),
    .RdAddr     (rd_addr),
    .cs         (cs),
    .Fill       (fill),
    .Q          (q),
    .RdValid    (rd_valid),
    .FillBusy   (fill_busy),
    .FillDone   (fill_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0;
    rd_en = 1'b0;
    fill  = 1'b0;
    ce    = 1'b1;
    tick  = 1'b1;
  endtask

  task automatic do_write(input int addr, input logic [NB-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AB'(addr);
    d       = data;
    if (addr < NW) model[addr] = data;
    tick_clk();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input int addr);
    rd_en   = 1'b1;
    rd_addr = AB'(addr);
    if (addr < NW) exp_q.push_back(model[addr]);
    else           exp_q.push_back(8'h00);
    tick_clk();
    rd_en = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < NW; a++) do_read(a);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_pos;

    idle_inputs();
    cs      = 1'b0;
    reset   = 1'b1;
    wr_addr = '0;
    rd_addr = '0;
    d       = '0;

    // Scoreboard monitor: each RdValid strobe consumes exactly one expected word.
    fork
      forever begin
        @(negedge clock);
        if (rd_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_rdvalid: got strobe with Q=%0h expected none", q);
          end else begin
            check("read_data", q, exp_q.pop_front());
          end
        end
      end
    join_none

    // Reset state
    tick_clk();
    tick_clk();
    reset = 1'b0;
    for (int i = 0; i < NW; i++) model[i] = 8'h00;
    check("reset_q", q, 8'h00);
    check("reset_rdvalid", rd_valid, 1'b0);
    check("reset_busy", fill_busy, 1'b0);
    check("reset_done", fill_done, 1'b0);
    read_all();

    // Basic write then read
    do_write(3, 8'hA5);
    do_read(3);

    // Cycles without a step: no write lands and no read strobe appears
    tick  = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd3; d = 8'h77;
    rd_en = 1'b1; rd_addr = 5'd3;
    tick_clk();
    ce    = 1'b0; tick = 1'b1;
    tick_clk();
    idle_inputs();
    tick_clk();
    do_read(3);

    // Out-of-range write is dropped and must not alias onto word 4
    do_write(20, 8'h99);
    do_read(20);
    do_read(4);
    do_read(3);

    // Read and write to the same address on the same step
    do_write(7, 8'h11);
    wr_en = 1'b1; wr_addr = 5'd7; d = 8'h3C;
    rd_en = 1'b1; rd_addr = 5'd7;
`ifdef MEM_RDW_BYPASS_EN
    exp_q.push_back(8'h3C);
`else
    exp_q.push_back(8'h11);
`endif
    model[7] = 8'h3C;
    tick_clk();
    idle_inputs();
    do_read(7);

    // Tri-state: the value held in the read register survives cs toggling
    tick_clk();
    tick_clk();
    cs = 1'b1;
    #1;
    checks++;
    if (!((q === 8'bzzzz_zzzz) || (q === 8'h00))) begin
      fails++;
      $display("FAIL cs_highz: got %0h expected zz", q);
    end
    tick_clk();
    cs = 1'b0;
    #1;
    check("cs_restore", q, 8'h3C);

    // Bulk fill: Fill and WrEn stay high during the sweep and must be ignored
    busy_cnt = 0; done_cnt = 0; done_pos = 0;
    fill = 1'b1;
    tick_clk();
    for (int k = 1; k <= 40; k++) begin
      if (fill_busy) busy_cnt++;
      if (fill_done) begin
        done_cnt++;
        if (done_pos == 0) done_pos = k;
      end
      if (fill_busy && !fill_done) begin
        wr_en = 1'b1; wr_addr = 5'd0; d = 8'h12; fill = 1'b1;
      end else begin
        wr_en = 1'b0; fill = 1'b0;
      end
      if (k == 1) begin
        rd_en = 1'b1; rd_addr = 5'd15;
        exp_q.push_back(model[15]);
      end else begin
        rd_en = 1'b0;
      end
      tick_clk();
    end
    idle_inputs();
    check("fill_busy_clocks", busy_cnt, 17);
    check("fill_done_pos", done_pos, 17);
    check("fill_done_count", done_cnt, 1);
    for (int i = 0; i < NW; i++) model[i] = 8'hFF;
    read_all();

    // Reset in the middle of a sweep (ptr = 5) aborts and clears the bank
    fill = 1'b1;
    tick_clk();
    fill = 1'b0;
    repeat (5) tick_clk();
    check("mid_sweep_busy", fill_busy, 1'b1);
    reset = 1'b1;
    tick_clk();
    reset = 1'b0;
    for (int i = 0; i < NW; i++) model[i] = 8'h00;
    check("abort_busy", fill_busy, 1'b0);
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (fill_busy) busy_cnt++;
      if (fill_done) done_cnt++;
      tick_clk();
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_stays_idle", busy_cnt, 0);
    read_all();

    repeat (3) tick_clk();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
